// File: rtl/uart_rx_cmd_parser_pkg.sv
// Shared definitions for the UART command-frame parser: opcode bytes,
// command type encodings and the parser FSM state encoding.
package uart_rx_cmd_parser_pkg;

    localparam logic [7:0] OP_WR  = 8'hAA;
    localparam logic [7:0] OP_RD  = 8'hBB;
    localparam logic [7:0] OP_ALU = 8'hCC;
    localparam logic [7:0] OP_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_WR      = 2'd0,
        CMD_RD      = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_GET_OPA  = 3'd3,
        ST_GET_OPB  = 3'd4,
        ST_GET_FUN  = 3'd5,
        ST_ISSUE    = 3'd6
    } state_e;

    // True while a frame is partially received and the inter-byte timer runs.
    function automatic logic is_get_state(state_e s);
        return (s == ST_GET_ADDR) || (s == ST_GET_DATA) || (s == ST_GET_OPA) ||
               (s == ST_GET_OPB)  || (s == ST_GET_FUN);
    endfunction

endpackage

// File: rtl/uart_rx_cmd_timer.sv
// Inter-byte idle counter: counts enabled cycles, saturates, and flags expiry
// when the count reaches a non-zero limit.
module uart_rx_cmd_timer #(
    parameter int TIMEOUT_WD = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic [TIMEOUT_WD-1:0] limit_i,
    output logic                  expired_o
);

    logic [TIMEOUT_WD-1:0] cnt_q;
    logic [TIMEOUT_WD-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !(&cnt_q)) begin
            cnt_d = cnt_q + TIMEOUT_WD'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (limit_i != '0) && (cnt_q == limit_i);

endmodule

// File: rtl/uart_rx_cmd_parser.sv
// Assembles received UART bytes into WR/RD/ALU command frames and presents each
// complete command once on a valid/ready interface; bad frames pulse frame_err_o.
module uart_rx_cmd_parser
    import uart_rx_cmd_parser_pkg::*;
#(
    parameter int DATA_WD    = 8,
    parameter int ADDR_WD    = 4,
    parameter int FUN_WD     = 4,
    parameter int TIMEOUT_WD = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WD-1:0]    rx_data_i,
    input  logic                  rx_valid_i,
    input  logic                  rx_err_i,
    input  logic [TIMEOUT_WD-1:0] timeout_lim_i,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [1:0]            cmd_type_o,
    output logic [ADDR_WD-1:0]    cmd_addr_o,
    output logic [DATA_WD-1:0]    cmd_wdata_o,
    output logic [DATA_WD-1:0]    cmd_opa_o,
    output logic [DATA_WD-1:0]    cmd_opb_o,
    output logic [FUN_WD-1:0]     cmd_fun_o,
    output logic                  frame_err_o,
    output logic                  busy_o
);

    state_e               state_q;
    cmd_type_e            cmd_type_q;
    logic                 cmd_valid_q;
    logic                 frame_err_q;
    logic [ADDR_WD-1:0]   addr_q;
    logic [DATA_WD-1:0]   wdata_q;
    logic [DATA_WD-1:0]   opa_q;
    logic [DATA_WD-1:0]   opb_q;
    logic [FUN_WD-1:0]    fun_q;

    logic in_get;
    logic accept;
    logic expired;

    assign in_get = is_get_state(state_q);
    assign accept = rx_valid_i && !rx_err_i;

    uart_rx_cmd_timer #(
        .TIMEOUT_WD (TIMEOUT_WD)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (!in_get || accept),
        .enable_i  (in_get),
        .limit_i   (timeout_lim_i),
        .expired_o (expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cmd_type_q  <= CMD_WR;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            fun_q       <= '0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cmd_valid_q <= 1'b0;
                    if (rx_valid_i) begin
                        if (rx_err_i) begin
                            frame_err_q <= 1'b1;
                        end else if (rx_data_i == DATA_WD'(OP_WR)) begin
                            cmd_type_q <= CMD_WR;
                            state_q    <= ST_GET_ADDR;
                        end else if (rx_data_i == DATA_WD'(OP_RD)) begin
                            cmd_type_q <= CMD_RD;
                            state_q    <= ST_GET_ADDR;
                        end else if (rx_data_i == DATA_WD'(OP_ALU)) begin
                            cmd_type_q <= CMD_ALU_OP;
                            state_q    <= ST_GET_OPA;
                        end else if (rx_data_i == DATA_WD'(OP_NOP)) begin
                            cmd_type_q <= CMD_ALU_NOP;
                            state_q    <= ST_GET_FUN;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                ST_GET_ADDR, ST_GET_DATA, ST_GET_OPA, ST_GET_OPB, ST_GET_FUN: begin
                    // An arriving byte takes priority over a timer expiring in the same cycle.
                    if (rx_valid_i) begin
                        if (rx_err_i) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            case (state_q)
                                ST_GET_ADDR: begin
                                    addr_q <= rx_data_i[ADDR_WD-1:0];
                                    if (cmd_type_q == CMD_WR) begin
                                        state_q <= ST_GET_DATA;
                                    end else begin
                                        state_q     <= ST_ISSUE;
                                        cmd_valid_q <= 1'b1;
                                    end
                                end
                                ST_GET_DATA: begin
                                    wdata_q     <= rx_data_i;
                                    state_q     <= ST_ISSUE;
                                    cmd_valid_q <= 1'b1;
                                end
                                ST_GET_OPA: begin
                                    opa_q   <= rx_data_i;
                                    state_q <= ST_GET_OPB;
                                end
                                ST_GET_OPB: begin
                                    opb_q   <= rx_data_i;
                                    state_q <= ST_GET_FUN;
                                end
                                default: begin
                                    fun_q       <= rx_data_i[FUN_WD-1:0];
                                    state_q     <= ST_ISSUE;
                                    cmd_valid_q <= 1'b1;
                                end
                            endcase
                        end
                    end else if (expired) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // Overrun: bytes arriving while a command is pending are dropped.
                    if (rx_valid_i) begin
                        frame_err_q <= 1'b1;
                    end
                    if (cmd_ready_i) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    cmd_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_type_o  = cmd_type_q;
    assign cmd_addr_o  = addr_q;
    assign cmd_wdata_o = wdata_q;
    assign cmd_opa_o   = opa_q;
    assign cmd_opb_o   = opb_q;
    assign cmd_fun_o   = fun_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Directed bench for uart_rx_cmd_parser: a table of complete frames followed by
// hand-written backpressure, overrun, timeout and reset sequences.
module tb_uart_rx_cmd_parser;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic [15:0] timeout_lim;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [7:0]  cmd_opa;
    logic [7:0]  cmd_opb;
    logic [3:0]  cmd_fun;
    logic        frame_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int xfers  = 0;
    int ferr_cnt = 0;

    uart_rx_cmd_parser dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .rx_err_i      (rx_err),
        .timeout_lim_i (timeout_lim),
        .cmd_valid_o   (cmd_valid),
        .cmd_ready_i   (cmd_ready),
        .cmd_type_o    (cmd_type),
        .cmd_addr_o    (cmd_addr),
        .cmd_wdata_o   (cmd_wdata),
        .cmd_opa_o     (cmd_opa),
        .cmd_opb_o     (cmd_opb),
        .cmd_fun_o     (cmd_fun),
        .frame_err_o   (frame_err),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) xfers++;
        if (frame_err) ferr_cnt++;
    end

    typedef struct {
        int          n;
        logic [31:0] bytes;    // byte 0 in [31:24]
        logic [3:0]  errm;     // bit i set: byte i carries rx_err
        bit          exp_cmd;
        logic [1:0]  typ;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  opa;
        logic [7:0]  opb;
        logic [3:0]  fun;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_err   = e;
        tick();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_type"},  32'(cmd_type),  32'd0);
        check({tag, "_addr"},  32'(cmd_addr),  32'd0);
        check({tag, "_wdata"}, 32'(cmd_wdata), 32'd0);
        check({tag, "_opa"},   32'(cmd_opa),   32'd0);
        check({tag, "_opb"},   32'(cmd_opb),   32'd0);
        check({tag, "_fun"},   32'(cmd_fun),   32'd0);
        check({tag, "_ferr"},  32'(frame_err), 32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        int exp_xfers;
        int x0;
        int f0;

        vecs[0] = '{3, 32'hAA053C00, 4'b0000, 1'b1, 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0};
        vecs[1] = '{2, 32'hBB070000, 4'b0010, 1'b0, 2'd1, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0};
        vecs[2] = '{2, 32'hBB070000, 4'b0000, 1'b1, 2'd1, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0};
        vecs[3] = '{1, 32'h55000000, 4'b0000, 1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0};
        vecs[4] = '{2, 32'hDD030000, 4'b0000, 1'b1, 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3};
        vecs[5] = '{4, 32'hCC123401, 4'b0000, 1'b1, 2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1};
        vecs[6] = '{3, 32'hAA1FFF00, 4'b0000, 1'b1, 2'd0, 4'hF, 8'hFF, 8'h00, 8'h00, 4'h0};
        vecs[7] = '{1, 32'hAA000000, 4'b0001, 1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0};
        vecs[8] = '{4, 32'hCC112209, 4'b1000, 1'b0, 2'd2, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0};
        vecs[9] = '{2, 32'hDD7E0000, 4'b0000, 1'b1, 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hE};

        rst_n       = 1'b0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        rx_err      = 1'b0;
        timeout_lim = 16'd0;
        cmd_ready   = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Table-driven frames, consumer always ready.
        exp_xfers = 0;
        x0 = xfers;
        for (int v = 0; v < NVEC; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(vecs[v].bytes[31-8*i -: 8], vecs[v].errm[i]);
                if (i < vecs[v].n - 1) begin
                    check($sformatf("v%0d_b%0d_busy", v, i), 32'(busy), 32'd1);
                    check($sformatf("v%0d_b%0d_valid", v, i), 32'(cmd_valid), 32'd0);
                end
            end
            check($sformatf("v%0d_valid", v), 32'(cmd_valid), 32'(vecs[v].exp_cmd));
            check($sformatf("v%0d_ferr", v), 32'(frame_err), 32'(!vecs[v].exp_cmd));
            if (vecs[v].exp_cmd) begin
                exp_xfers++;
                check($sformatf("v%0d_type", v), 32'(cmd_type), 32'(vecs[v].typ));
                if (vecs[v].typ == 2'd0 || vecs[v].typ == 2'd1)
                    check($sformatf("v%0d_addr", v), 32'(cmd_addr), 32'(vecs[v].addr));
                if (vecs[v].typ == 2'd0)
                    check($sformatf("v%0d_wdata", v), 32'(cmd_wdata), 32'(vecs[v].wdata));
                if (vecs[v].typ == 2'd2) begin
                    check($sformatf("v%0d_opa", v), 32'(cmd_opa), 32'(vecs[v].opa));
                    check($sformatf("v%0d_opb", v), 32'(cmd_opb), 32'(vecs[v].opb));
                end
                if (vecs[v].typ >= 2'd2)
                    check($sformatf("v%0d_fun", v), 32'(cmd_fun), 32'(vecs[v].fun));
            end else begin
                check($sformatf("v%0d_idle", v), 32'(busy), 32'd0);
            end
            tick();
            check($sformatf("v%0d_after_valid", v), 32'(cmd_valid), 32'd0);
            check($sformatf("v%0d_after_busy", v), 32'(busy), 32'd0);
            check($sformatf("v%0d_after_ferr", v), 32'(frame_err), 32'd0);
            $display("vector %0d: %0d bytes, cmd=%0d", v, vecs[v].n, vecs[v].exp_cmd);
        end
        check("table_xfers", 32'(xfers - x0), 32'(exp_xfers));

        // Backpressure, then overrun with and without a simultaneous accept.
        cmd_ready = 1'b0;
        x0 = xfers;
        send_byte(8'hCC, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h01, 1'b0);
        check("bp_valid_rise", 32'(cmd_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp_hold%0d", c), 32'(cmd_valid), 32'd1);
        end
        send_byte(8'h99, 1'b0);
        check("ovr_ferr", 32'(frame_err), 32'd1);
        check("ovr_valid", 32'(cmd_valid), 32'd1);
        check("ovr_opa", 32'(cmd_opa), 32'h12);
        check("ovr_opb", 32'(cmd_opb), 32'h34);
        check("ovr_fun", 32'(cmd_fun), 32'h1);
        check("ovr_type", 32'(cmd_type), 32'd2);
        cmd_ready = 1'b1;
        send_byte(8'h77, 1'b0);
        check("ovr_rdy_ferr", 32'(frame_err), 32'd1);
        check("ovr_rdy_valid", 32'(cmd_valid), 32'd0);
        check("ovr_rdy_busy", 32'(busy), 32'd0);
        tick();
        check("ovr_ferr_end", 32'(frame_err), 32'd0);
        check("bp_xfers", 32'(xfers - x0), 32'd1);
        $display("backpressure/overrun sequence done");

        // Timeout: counter reaches 10 after the 10th idle cycle, abort lands on the next edge.
        timeout_lim = 16'd10;
        send_byte(8'hDD, 1'b0);
        repeat (10) tick();
        check("to_busy_pre", 32'(busy), 32'd1);
        check("to_ferr_pre", 32'(frame_err), 32'd0);
        tick();
        check("to_ferr", 32'(frame_err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        tick();
        check("to_ferr_end", 32'(frame_err), 32'd0);
        $display("timeout expiry sequence done");

        // Byte arriving on the expiry cycle is accepted.
        send_byte(8'hDD, 1'b0);
        repeat (10) tick();
        send_byte(8'h05, 1'b0);
        check("to_race_valid", 32'(cmd_valid), 32'd1);
        check("to_race_ferr", 32'(frame_err), 32'd0);
        check("to_race_fun", 32'(cmd_fun), 32'h5);
        tick();
        $display("timeout race sequence done");

        // Disabled timeout waits indefinitely.
        timeout_lim = 16'd0;
        f0 = ferr_cnt;
        send_byte(8'hDD, 1'b0);
        repeat (200) tick();
        check("notimeout_busy", 32'(busy), 32'd1);
        check("notimeout_ferr", 32'(ferr_cnt - f0), 32'd0);
        send_byte(8'h0B, 1'b0);
        check("notimeout_valid", 32'(cmd_valid), 32'd1);
        check("notimeout_fun", 32'(cmd_fun), 32'hB);
        tick();
        $display("disabled timeout sequence done");

        // Asynchronous reset while in GET_OPB.
        send_byte(8'hCC, 1'b0);
        send_byte(8'h5A, 1'b0);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        send_byte(8'hDD, 1'b0);
        send_byte(8'h03, 1'b0);
        check("postrst_valid", 32'(cmd_valid), 32'd1);
        check("postrst_type", 32'(cmd_type), 32'd3);
        check("postrst_fun", 32'(cmd_fun), 32'd3);
        tick();
        check("postrst_idle", 32'(busy), 32'd0);
        $display("reset sequence done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
